// File: rtl/rl_pkg.sv
// Shared widths, PE state encoding, filter-buffer entry layout and the pair filter rule
// for the range-limited force evaluation slice.
package rl_pkg;

  localparam int X_DIM                    = 4;
  localparam int Y_DIM                    = 4;
  localparam int Z_DIM                    = 4;
  localparam int NUM_PARTICLE_PER_CELL    = 100;
  localparam int NUM_NEIGHBOR_CELLS       = 13;
  localparam int DATA_WIDTH               = 32;
  localparam int PARTICLE_ID_WIDTH        = 7;
  localparam int NEIGHBOR_WIDTH           = 4;
  localparam int FILTER_BUFFER_DATA_WIDTH = PARTICLE_ID_WIDTH + 3 * DATA_WIDTH;
  localparam int FILTER_DEPTH             = 16;
  localparam int FILTER_PTR_WIDTH         = 4;
  localparam int FILTER_CNT_WIDTH         = 5;
  localparam int FORCE_LATENCY            = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } pe_state_e;

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0] pid;
    logic [3*DATA_WIDTH-1:0]      payload;
  } fb_entry_t;

  // Only the low two bits of h+n matter for the modulo-4 test.
  function automatic logic pair_accept(input logic [NEIGHBOR_WIDTH-1:0] n,
                                       input logic [PARTICLE_ID_WIDTH-1:0] h);
    logic [1:0] mod4;
    mod4 = h[1:0] + n[1:0];
    return (mod4 != 2'd3);
  endfunction

endpackage

// File: rtl/rl_cell_pe.sv
// One cell PE: pair generator FSM, one-cycle filter stage, 16-entry filter buffer and force pipe.
// RL_ACCEPT_ALL_EN makes the filter accept every candidate pair.
module rl_cell_pe
  import rl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic reading_done,
  output logic back_pressure,
  output logic filter_buffer_empty,
  output logic force_valid
);

  pe_state_e                    r_state;
  pe_state_e                    w_state_nxt;
  logic [NEIGHBOR_WIDTH-1:0]    r_n;
  logic [NEIGHBOR_WIDTH-1:0]    r_cand_n;
  logic [PARTICLE_ID_WIDTH-1:0] r_h;
  logic [PARTICLE_ID_WIDTH-1:0] r_cand_h;
  logic                         r_cand_valid;
  logic                         w_issue;
  logic                         w_last;
  logic                         w_accept;
  logic                         w_push;
  logic                         w_pop;
  fb_entry_t                    w_push_entry;
  fb_entry_t                    r_mem [FILTER_DEPTH];
  logic [FILTER_PTR_WIDTH-1:0]  r_wr_ptr;
  logic [FILTER_PTR_WIDTH-1:0]  r_rd_ptr;
  logic [FILTER_CNT_WIDTH-1:0]  r_count;
  logic [FILTER_CNT_WIDTH-1:0]  w_count_nxt;
  logic                         r_pop_last;
  logic [FORCE_LATENCY-1:0]     r_pipe_valid;
  logic [PARTICLE_ID_WIDTH-1:0] r_pipe_pid [FORCE_LATENCY];
  logic                         r_reading_done;
  logic                         r_back_pressure;
  logic                         r_empty;
  logic                         r_force_valid;

  always_comb begin
    w_issue = (r_state == S_READ) && !r_back_pressure;
    w_last  = (r_n == NEIGHBOR_WIDTH'(NUM_NEIGHBOR_CELLS)) &&
              (r_h == PARTICLE_ID_WIDTH'(NUM_PARTICLE_PER_CELL - 1));
`ifdef RL_ACCEPT_ALL_EN
    w_accept = 1'b1;
`else
    w_accept = pair_accept(r_cand_n, r_cand_h);
`endif
    w_push = r_cand_valid && w_accept;
    // Initiation interval of 2: never pop in the cycle right after a pop.
    w_pop       = (r_count != {FILTER_CNT_WIDTH{1'b0}}) && !r_pop_last;
    w_count_nxt = r_count + FILTER_CNT_WIDTH'(w_push) - FILTER_CNT_WIDTH'(w_pop);
    w_push_entry.pid     = r_cand_h;
    w_push_entry.payload = {{(3*DATA_WIDTH-NEIGHBOR_WIDTH-PARTICLE_ID_WIDTH){1'b0}},
                            r_cand_n, r_cand_h};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_READ; else w_state_nxt = S_IDLE;
      S_READ:  if (w_issue && w_last) w_state_nxt = S_DRAIN; else w_state_nxt = S_READ;
      S_DRAIN: if (!r_cand_valid && (r_count == {FILTER_CNT_WIDTH{1'b0}}) &&
                   (r_pipe_valid == {FORCE_LATENCY{1'b0}})) w_state_nxt = S_DONE;
               else w_state_nxt = S_DRAIN;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n             <= {NEIGHBOR_WIDTH{1'b0}};
      r_h             <= {PARTICLE_ID_WIDTH{1'b0}};
      r_cand_valid    <= 1'b0;
      r_cand_n        <= {NEIGHBOR_WIDTH{1'b0}};
      r_cand_h        <= {PARTICLE_ID_WIDTH{1'b0}};
      r_wr_ptr        <= {FILTER_PTR_WIDTH{1'b0}};
      r_rd_ptr        <= {FILTER_PTR_WIDTH{1'b0}};
      r_count         <= {FILTER_CNT_WIDTH{1'b0}};
      r_pop_last      <= 1'b0;
      r_pipe_valid    <= {FORCE_LATENCY{1'b0}};
      r_reading_done  <= 1'b0;
      r_back_pressure <= 1'b0;
      r_empty         <= 1'b1;
      r_force_valid   <= 1'b0;
    end else begin
      if (w_issue) begin
        if (r_h == PARTICLE_ID_WIDTH'(NUM_PARTICLE_PER_CELL - 1)) begin
          r_h <= {PARTICLE_ID_WIDTH{1'b0}};
          r_n <= r_n + NEIGHBOR_WIDTH'(1);
        end else begin
          r_h <= r_h + PARTICLE_ID_WIDTH'(1);
        end
      end
      r_cand_valid <= w_issue;
      r_cand_n     <= r_n;
      r_cand_h     <= r_h;
      if (w_push) r_wr_ptr <= r_wr_ptr + FILTER_PTR_WIDTH'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FILTER_PTR_WIDTH'(1);
      r_count      <= w_count_nxt;
      r_pop_last   <= w_pop;
      r_pipe_valid <= {r_pipe_valid[FORCE_LATENCY-2:0], w_pop};
      if (w_issue && w_last) r_reading_done <= 1'b1;
      // Flags reflect the count as it will be after this edge.
      r_back_pressure <= (w_count_nxt >= FILTER_CNT_WIDTH'(FILTER_DEPTH - 2));
      r_empty         <= (w_count_nxt == {FILTER_CNT_WIDTH{1'b0}});
      if (r_state == S_DONE) r_force_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_entry;
    r_pipe_pid[0] <= r_mem[r_rd_ptr].pid;
    for (int i = 1; i < FORCE_LATENCY; i++) r_pipe_pid[i] <= r_pipe_pid[i-1];
  end

  assign reading_done        = r_reading_done;
  assign back_pressure       = r_back_pressure;
  assign filter_buffer_empty = r_empty;
  assign force_valid         = r_force_valid;

endmodule

// File: rtl/rl_top.sv
// Range-limited force evaluation top: NUM_CELLS lockstep cell PEs plus a registered all-done flag.
// RL_ACCEPT_ALL_EN (see rl_cell_pe) disables pair filtering.
module rl_top
  import rl_pkg::*;
#(
  parameter int NUM_CELLS = X_DIM * Y_DIM * Z_DIM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [NUM_CELLS-1:0] reading_done,
  output logic [NUM_CELLS-1:0] back_pressure,
  output logic [NUM_CELLS-1:0] filter_buffer_empty,
  output logic [NUM_CELLS-1:0] force_valid,
  output logic                 force_valid_and
);

  logic [NUM_CELLS-1:0] w_force_valid;
  logic                 r_force_valid_and;

  for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
    rl_cell_pe u_pe (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .reading_done        (reading_done[gi]),
      .back_pressure       (back_pressure[gi]),
      .filter_buffer_empty (filter_buffer_empty[gi]),
      .force_valid         (w_force_valid[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_force_valid_and <= 1'b0;
    else     r_force_valid_and <= &w_force_valid;
  end

  assign force_valid     = w_force_valid;
  assign force_valid_and = r_force_valid_and;

endmodule

// File: tb/tb_rl_top.sv
// Directed self-checking bench for rl_top; expected pair counts follow RL_ACCEPT_ALL_EN.
module tb_rl_top;

  localparam int NC = 64;
  localparam int EXP_ISSUE = 1400;
`ifdef RL_ACCEPT_ALL_EN
  localparam int EXP_PUSH = 1400;
  localparam int FVA_MIN  = 2800;
  localparam int FVA_MAX  = 2800 + 4 + 20;
`else
  localparam int EXP_PUSH = 1050;
  localparam int FVA_MIN  = 2100;
  localparam int FVA_MAX  = 2100 + 4 + 20;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [NC-1:0] reading_done;
  logic [NC-1:0] back_pressure;
  logic [NC-1:0] filter_buffer_empty;
  logic [NC-1:0] force_valid;
  logic          force_valid_and;
  logic [NC-1:0] all_ones;
  int            total;
  int            bad;

  rl_top #(.NUM_CELLS(NC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .reading_done        (reading_done),
    .back_pressure       (back_pressure),
    .filter_buffer_empty (filter_buffer_empty),
    .force_valid         (force_valid),
    .force_valid_and     (force_valid_and)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    bit fv_seen;
    rst = 1'b1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    total++; if (reading_done !== {NC{1'b0}}) begin bad++; $display("FAIL reset_reading_done got=%h exp=0", reading_done); end
    total++; if (back_pressure !== {NC{1'b0}}) begin bad++; $display("FAIL reset_back_pressure got=%h exp=0", back_pressure); end
    total++; if (filter_buffer_empty !== all_ones) begin bad++; $display("FAIL reset_fb_empty got=%h exp=%h", filter_buffer_empty, all_ones); end
    total++; if (force_valid !== {NC{1'b0}}) begin bad++; $display("FAIL reset_force_valid got=%h exp=0", force_valid); end
    total++; if (force_valid_and !== 1'b0) begin bad++; $display("FAIL reset_force_valid_and got=%b exp=0", force_valid_and); end
    fv_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (force_valid !== {NC{1'b0}} || force_valid_and !== 1'b0) fv_seen = 1'b1;
    end
    total++; if (fv_seen !== 1'b0) begin bad++; $display("FAIL idle_force_valid got=%b exp=0", fv_seen); end
  endtask

  task automatic test_run();
    int   cyc = 0;
    int   fva_cyc = 0;
    int   rd_cyc = 0;
    int   iss0 = 0, iss63 = 0, push0 = 0, pop0 = 0, pop63 = 0;
    int   bp_rise = 0;
    int   max_cnt = 0;
    logic bp_prev = 1'b0;
    start = 1'b1;
    while (fva_cyc == 0 && cyc < 4000) begin
      if (dut.g_cell[0].u_pe.w_issue === 1'b1)  iss0++;
      if (dut.g_cell[63].u_pe.w_issue === 1'b1) iss63++;
      if (dut.g_cell[0].u_pe.w_push === 1'b1)   push0++;
      if (dut.g_cell[0].u_pe.w_pop === 1'b1)    pop0++;
      if (dut.g_cell[63].u_pe.w_pop === 1'b1)   pop63++;
      @(negedge clk);
      cyc++;
      if (cyc == 50) start = 1'b0;
      if (int'(dut.g_cell[0].u_pe.r_count) > max_cnt) max_cnt = int'(dut.g_cell[0].u_pe.r_count);
      if (back_pressure[0] === 1'b1 && bp_prev === 1'b0) bp_rise++;
      bp_prev = back_pressure[0];
      if (reading_done[0] === 1'b1 && rd_cyc == 0) begin
        rd_cyc = cyc;
        total++; if (filter_buffer_empty !== {NC{1'b0}}) begin bad++; $display("FAIL drain_fb_empty got=%h exp=0", filter_buffer_empty); end
      end
      if (force_valid_and === 1'b1) fva_cyc = cyc;
    end
    total++; if (fva_cyc == 0) begin bad++; $display("FAIL run_timeout got=no_done exp=done_within_4000"); end
    total++; if (fva_cyc < FVA_MIN || fva_cyc > FVA_MAX) begin bad++; $display("FAIL run_fva_cycle got=%0d exp=%0d..%0d", fva_cyc, FVA_MIN, FVA_MAX); end
    total++; if (iss0 != EXP_ISSUE) begin bad++; $display("FAIL run_issue_pe0 got=%0d exp=%0d", iss0, EXP_ISSUE); end
    total++; if (iss63 != EXP_ISSUE) begin bad++; $display("FAIL run_issue_pe63 got=%0d exp=%0d", iss63, EXP_ISSUE); end
    total++; if (push0 != EXP_PUSH) begin bad++; $display("FAIL run_push_pe0 got=%0d exp=%0d", push0, EXP_PUSH); end
    total++; if (pop0 != EXP_PUSH) begin bad++; $display("FAIL run_pop_pe0 got=%0d exp=%0d", pop0, EXP_PUSH); end
    total++; if (pop63 != EXP_PUSH) begin bad++; $display("FAIL run_pop_pe63 got=%0d exp=%0d", pop63, EXP_PUSH); end
    total++; if (rd_cyc < EXP_ISSUE) begin bad++; $display("FAIL run_reading_done_cycle got=%0d exp>=%0d", rd_cyc, EXP_ISSUE); end
    total++; if (bp_rise < 2) begin bad++; $display("FAIL run_bp_toggle got=%0d exp>=2", bp_rise); end
    total++; if (max_cnt > 16) begin bad++; $display("FAIL run_max_count got=%0d exp<=16", max_cnt); end
    total++; if (reading_done !== all_ones) begin bad++; $display("FAIL run_reading_done got=%h exp=%h", reading_done, all_ones); end
    total++; if (force_valid !== all_ones) begin bad++; $display("FAIL run_force_valid got=%h exp=%h", force_valid, all_ones); end
  endtask

  task automatic test_hold_after_done();
    int iss = 0;
    bit dropped = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (dut.g_cell[0].u_pe.w_issue === 1'b1) iss++;
      @(negedge clk);
      if (force_valid !== all_ones || force_valid_and !== 1'b1) dropped = 1'b1;
    end
    start = 1'b0;
    total++; if (iss != 0) begin bad++; $display("FAIL hold_issue got=%0d exp=0", iss); end
    total++; if (dropped !== 1'b0) begin bad++; $display("FAIL hold_force_valid got=dropped exp=held"); end
    total++; if (reading_done !== all_ones) begin bad++; $display("FAIL hold_reading_done got=%h exp=%h", reading_done, all_ones); end
  endtask

  task automatic test_rst_mid_run();
    int iss = 0;
    int cyc = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    repeat (500) @(negedge clk);
    total++; if (filter_buffer_empty !== {NC{1'b0}}) begin bad++; $display("FAIL mid_fb_busy got=%h exp=0", filter_buffer_empty); end
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    total++; if (reading_done !== {NC{1'b0}}) begin bad++; $display("FAIL mid_rst_reading_done got=%h exp=0", reading_done); end
    total++; if (back_pressure !== {NC{1'b0}}) begin bad++; $display("FAIL mid_rst_back_pressure got=%h exp=0", back_pressure); end
    total++; if (filter_buffer_empty !== all_ones) begin bad++; $display("FAIL mid_rst_fb_empty got=%h exp=%h", filter_buffer_empty, all_ones); end
    total++; if (force_valid !== {NC{1'b0}} || force_valid_and !== 1'b0) begin bad++; $display("FAIL mid_rst_force_valid got=%h/%b exp=0/0", force_valid, force_valid_and); end
    for (int c = 0; c < 50; c++) begin
      if (dut.g_cell[0].u_pe.w_issue === 1'b1) iss++;
      @(negedge clk);
    end
    total++; if (iss != 0) begin bad++; $display("FAIL mid_no_restart got=%0d exp=0", iss); end
    total++; if (reading_done !== {NC{1'b0}}) begin bad++; $display("FAIL mid_idle_reading_done got=%h exp=0", reading_done); end
    start = 1'b1;
    while (force_valid_and !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    total++; if (force_valid_and !== 1'b1) begin bad++; $display("FAIL mid_restart_done got=%b exp=1", force_valid_and); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    all_ones = {NC{1'b1}};
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_run();
    test_hold_after_done();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
